fetch_ctrl: RTL and testbench

FETCH_CTRL -- requirements
Module: fetch_ctrl

---
 rtl/proc_pkg.sv | 15 +
 rtl/fetch_ctrl.sv | 163 ++++++++++++++++
 tb/tb_fetch_ctrl.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/proc_pkg.sv
// Shared processor definitions: default widths/depths and the fetch FSM state encoding.
package proc_pkg;

    localparam int PC_LEN_DEF = 32;
    localparam int W_DEF      = 32;
    localparam int D_DEF      = 128;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_HALTED = 3'd2,
        ST_FAULT  = 3'd3
    } fetch_state_e;

endpackage

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: drives ins_mem addresses, registers fetched words
// behind a valid/ready handshake, and handles redirect, halt and fault conditions.
module fetch_ctrl
    import proc_pkg::*;
#(
    parameter int                PC_LEN   = PC_LEN_DEF,
    parameter int                W        = W_DEF,
    parameter int                D        = D_DEF,
    parameter logic [PC_LEN-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              halt_req,
    input  logic              redirect_valid,
    input  logic [PC_LEN-1:0] redirect_pc,
    output logic [PC_LEN-1:0] pcaddress,
    input  logic [W-1:0]      instruction,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [W-1:0]      out_instr,
    output logic [PC_LEN-1:0] out_pc,
    output logic [2:0]        state,
    output logic              fault,
    output logic [15:0]       fetch_count
);

    localparam logic [PC_LEN:0]   PC_LIMIT = (PC_LEN + 1)'(4 * D);
    localparam logic [PC_LEN-1:0] LAST_PC  = PC_LEN'(4 * D - 4);
    localparam logic [PC_LEN-1:0] PC_STEP  = PC_LEN'(32'd4);

    fetch_state_e      state_q, state_d;
    logic [PC_LEN-1:0] pc_q, pc_d;
    logic              out_valid_q, out_valid_d;
    logic [W-1:0]      out_instr_q, out_instr_d;
    logic [PC_LEN-1:0] out_pc_q, out_pc_d;
    logic              fault_q, fault_d;
    logic [15:0]       fetch_count_q, fetch_count_d;

    logic accept;
    logic can_capture;
    logic redirect_bad;
    logic at_last;

    assign accept       = out_valid_q && out_ready;
    assign can_capture  = !out_valid_q || out_ready;
    assign redirect_bad = (redirect_pc[1:0] != 2'b00) || ({1'b0, redirect_pc} >= PC_LIMIT);
    // Advancing past the last word faults instead of wrapping.
    assign at_last      = (pc_q == LAST_PC);

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; redirect outranks halt, halt outranks start.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start) state_d = ST_FETCH;
                else       state_d = ST_IDLE;
            end
            ST_FETCH: begin
                if (redirect_valid) begin
                    if (redirect_bad) state_d = ST_FAULT;
                    else              state_d = ST_FETCH;
                end else if (halt_req) begin
                    state_d = ST_HALTED;
                end else if (can_capture && at_last) begin
                    state_d = ST_FAULT;
                end else begin
                    state_d = ST_FETCH;
                end
            end
            ST_HALTED: begin
                if (start && !halt_req) state_d = ST_FETCH;
                else                    state_d = ST_HALTED;
            end
            ST_FAULT: state_d = ST_FAULT;
            default:  state_d = ST_FAULT;
        endcase
    end

    // Datapath next values: PC, output register, fault flag and accept counter.
    always_comb begin
        pc_d        = pc_q;
        out_valid_d = out_valid_q;
        out_instr_d = out_instr_q;
        out_pc_d    = out_pc_q;
        if (accept && (fetch_count_q != 16'hFFFF)) fetch_count_d = fetch_count_q + 16'd1;
        else                                       fetch_count_d = fetch_count_q;

        case (state_q)
            ST_IDLE: begin
                pc_d        = RESET_PC;
                out_valid_d = 1'b0;
            end
            ST_FETCH: begin
                if (redirect_valid) begin
                    out_valid_d = 1'b0;
                    if (!redirect_bad) pc_d = redirect_pc;
                    else               pc_d = pc_q;
                end else if (halt_req) begin
                    out_valid_d = out_valid_q && !out_ready;
                end else if (can_capture) begin
                    if (at_last) begin
                        out_valid_d = 1'b0;
                    end else begin
                        out_instr_d = instruction;
                        out_pc_d    = pc_q;
                        out_valid_d = 1'b1;
                        pc_d        = pc_q + PC_STEP;
                    end
                end else begin
                    out_valid_d = out_valid_q;
                end
            end
            ST_HALTED: out_valid_d = out_valid_q && !out_ready;
            ST_FAULT:  out_valid_d = 1'b0;
            default:   out_valid_d = 1'b0;
        endcase

        if (state_d == ST_FAULT) begin
            fault_d     = 1'b1;
            out_valid_d = 1'b0;
        end else begin
            fault_d = fault_q;
        end
    end

    // Datapath registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q          <= RESET_PC;
            out_valid_q   <= 1'b0;
            out_instr_q   <= '0;
            out_pc_q      <= '0;
            fault_q       <= 1'b0;
            fetch_count_q <= 16'd0;
        end else begin
            pc_q          <= pc_d;
            out_valid_q   <= out_valid_d;
            out_instr_q   <= out_instr_d;
            out_pc_q      <= out_pc_d;
            fault_q       <= fault_d;
            fetch_count_q <= fetch_count_d;
        end
    end

    assign pcaddress   = pc_q;
    assign out_valid   = out_valid_q;
    assign out_instr   = out_instr_q;
    assign out_pc      = out_pc_q;
    assign state       = state_q;
    assign fault       = fault_q;
    assign fetch_count = fetch_count_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: directed vector table, then randomized traffic against a reference model.
module tb_fetch_ctrl;

    localparam int D = 128;

    logic        clk = 1'b0;
    logic        rst_n, start, halt_req, redirect_valid, out_ready;
    logic [31:0] redirect_pc;
    logic [31:0] pcaddress, instruction, out_instr, out_pc;
    logic        out_valid, fault;
    logic [2:0]  state;
    logic [15:0] fetch_count;

    logic [31:0] mem [0:D-1];

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    assign instruction = (pcaddress < 32'(4 * D)) ? mem[pcaddress[8:2]] : 32'hDEAD_BEEF;

    fetch_ctrl #(.PC_LEN(32), .W(32), .D(D), .RESET_PC(32'h0)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .halt_req(halt_req),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .pcaddress(pcaddress), .instruction(instruction),
        .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
        .out_pc(out_pc), .state(state), .fault(fault), .fetch_count(fetch_count)
    );

    typedef struct {
        logic        rst_n, start, halt, redir;
        logic [31:0] rpc;
        logic        ready;
        logic [2:0]  st;
        logic [31:0] pc;
        logic        ov;
        logic [31:0] opc;
        logic        flt;
        logic [15:0] cnt;
    } vec_t;

    vec_t vq[$];

    task automatic add(input logic r, input logic s, input logic h, input logic rd,
                       input logic [31:0] rpc, input logic rdy, input logic [2:0] st,
                       input logic [31:0] pc, input logic ov, input logic [31:0] opc,
                       input logic flt, input logic [15:0] cnt);
        vec_t v;
        v.rst_n = r; v.start = s; v.halt = h; v.redir = rd; v.rpc = rpc; v.ready = rdy;
        v.st = st; v.pc = pc; v.ov = ov; v.opc = opc; v.flt = flt; v.cnt = cnt;
        vq.push_back(v);
    endtask

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @%0d: got %0h, expected %0h", name, idx, act, exp);
        end
    endtask

    // Reference model: spec-level behaviour kept in plain integers.
    int          m_st, m_pc, m_opc, m_cnt;
    logic        m_ov, m_flt;
    logic [31:0] m_oins;

    task automatic model_step();
        bit acc;
        acc = m_ov && out_ready;
        if (!rst_n) begin
            m_st = 0; m_pc = 0; m_ov = 1'b0; m_opc = 0; m_oins = 32'h0; m_flt = 1'b0; m_cnt = 0;
            return;
        end
        if (acc && m_cnt < 65535) m_cnt++;
        case (m_st)
            0: begin
                m_pc = 0; m_ov = 1'b0;
                if (start) m_st = 1;
            end
            1: begin
                if (redirect_valid) begin
                    m_ov = 1'b0;
                    if ((redirect_pc % 4) != 0 || redirect_pc >= 32'(4 * D)) begin
                        m_st = 3; m_flt = 1'b1;
                    end else begin
                        m_pc = int'(redirect_pc);
                    end
                end else if (halt_req) begin
                    m_st = 2;
                    if (acc) m_ov = 1'b0;
                end else if (!m_ov || out_ready) begin
                    if (m_pc + 4 >= 4 * D) begin
                        m_st = 3; m_flt = 1'b1; m_ov = 1'b0;
                    end else begin
                        m_opc = m_pc; m_oins = mem[m_pc / 4]; m_ov = 1'b1; m_pc += 4;
                    end
                end
            end
            2: begin
                if (acc) m_ov = 1'b0;
                if (start && !halt_req) m_st = 1;
            end
            default: m_ov = 1'b0;
        endcase
    endtask

    initial begin
        for (int i = 0; i < D; i++) mem[i] = $urandom;
        rst_n = 1'b0; start = 1'b0; halt_req = 1'b0; redirect_valid = 1'b0;
        redirect_pc = 32'h0; out_ready = 1'b0;

        //    rst s h rd rpc        rdy | st pc        ov opc       f cnt
        add(1'b0,1'b0,1'b0,1'b0,32'h0,  1'b0, 3'd0,32'h0,  1'b0,32'h0,  1'b0,16'd0); // reset
        add(1'b1,1'b1,1'b0,1'b0,32'h0,  1'b1, 3'd1,32'h0,  1'b0,32'h0,  1'b0,16'd0); // start
        add(1'b1,1'b0,1'b0,1'b0,32'h0,  1'b1, 3'd1,32'h4,  1'b1,32'h0,  1'b0,16'd0);
        add(1'b1,1'b0,1'b0,1'b0,32'h0,  1'b1, 3'd1,32'h8,  1'b1,32'h4,  1'b0,16'd1);
        add(1'b1,1'b0,1'b0,1'b0,32'h0,  1'b1, 3'd1,32'hC,  1'b1,32'h8,  1'b0,16'd2);
        add(1'b1,1'b0,1'b0,1'b0,32'h0,  1'b0, 3'd1,32'hC,  1'b1,32'h8,  1'b0,16'd2); // stall x3
        add(1'b1,1'b0,1'b0,1'b0,32'h0,  1'b0, 3'd1,32'hC,  1'b1,32'h8,  1'b0,16'd2);
        add(1'b1,1'b0,1'b0,1'b0,32'h0,  1'b0, 3'd1,32'hC,  1'b1,32'h8,  1'b0,16'd2);
        add(1'b1,1'b0,1'b0,1'b0,32'h0,  1'b1, 3'd1,32'h10, 1'b1,32'hC,  1'b0,16'd3);
        add(1'b1,1'b0,1'b0,1'b0,32'h0,  1'b1, 3'd1,32'h14, 1'b1,32'h10, 1'b0,16'd4);
        add(1'b1,1'b0,1'b0,1'b1,32'h40, 1'b1, 3'd1,32'h40, 1'b0,32'h10, 1'b0,16'd5); // redirect
        add(1'b1,1'b0,1'b0,1'b0,32'h0,  1'b1, 3'd1,32'h44, 1'b1,32'h40, 1'b0,16'd5);
        add(1'b1,1'b0,1'b0,1'b0,32'h0,  1'b0, 3'd1,32'h44, 1'b1,32'h40, 1'b0,16'd5);
        add(1'b1,1'b0,1'b0,1'b1,32'h10, 1'b1, 3'd1,32'h10, 1'b0,32'h40, 1'b0,16'd6);
        add(1'b1,1'b0,1'b1,1'b0,32'h0,  1'b1, 3'd2,32'h10, 1'b0,32'h40, 1'b0,16'd6); // halt
        add(1'b1,1'b1,1'b1,1'b0,32'h0,  1'b1, 3'd2,32'h10, 1'b0,32'h40, 1'b0,16'd6); // both
        add(1'b1,1'b0,1'b0,1'b0,32'h0,  1'b1, 3'd2,32'h10, 1'b0,32'h40, 1'b0,16'd6);
        add(1'b1,1'b1,1'b0,1'b0,32'h0,  1'b1, 3'd1,32'h10, 1'b0,32'h40, 1'b0,16'd6); // resume
        add(1'b1,1'b0,1'b0,1'b0,32'h0,  1'b1, 3'd1,32'h14, 1'b1,32'h10, 1'b0,16'd6);
        add(1'b1,1'b0,1'b0,1'b0,32'h0,  1'b1, 3'd1,32'h18, 1'b1,32'h14, 1'b0,16'd7);
        add(1'b1,1'b0,1'b1,1'b0,32'h0,  1'b0, 3'd2,32'h18, 1'b1,32'h14, 1'b0,16'd7); // halt, pending
        add(1'b1,1'b0,1'b0,1'b0,32'h0,  1'b0, 3'd2,32'h18, 1'b1,32'h14, 1'b0,16'd7);
        add(1'b1,1'b0,1'b0,1'b0,32'h0,  1'b1, 3'd2,32'h18, 1'b0,32'h14, 1'b0,16'd8);
        add(1'b1,1'b1,1'b0,1'b0,32'h0,  1'b1, 3'd1,32'h18, 1'b0,32'h14, 1'b0,16'd8);
        add(1'b1,1'b0,1'b0,1'b0,32'h0,  1'b0, 3'd1,32'h1C, 1'b1,32'h18, 1'b0,16'd8);
        add(1'b0,1'b1,1'b0,1'b0,32'h0,  1'b1, 3'd0,32'h0,  1'b0,32'h0,  1'b0,16'd0); // reset mid-fetch
        add(1'b1,1'b1,1'b0,1'b0,32'h0,  1'b0, 3'd1,32'h0,  1'b0,32'h0,  1'b0,16'd0);
        add(1'b1,1'b0,1'b0,1'b1,32'h42, 1'b1, 3'd3,32'h0,  1'b0,32'h0,  1'b1,16'd0); // misaligned
        add(1'b1,1'b1,1'b0,1'b0,32'h0,  1'b1, 3'd3,32'h0,  1'b0,32'h0,  1'b1,16'd0);
        add(1'b1,1'b1,1'b1,1'b1,32'h40, 1'b1, 3'd3,32'h0,  1'b0,32'h0,  1'b1,16'd0);
        add(1'b0,1'b0,1'b0,1'b0,32'h0,  1'b0, 3'd0,32'h0,  1'b0,32'h0,  1'b0,16'd0);
        add(1'b1,1'b1,1'b0,1'b0,32'h0,  1'b0, 3'd1,32'h0,  1'b0,32'h0,  1'b0,16'd0);
        add(1'b1,1'b0,1'b0,1'b1,32'h1F8,1'b1, 3'd1,32'h1F8,1'b0,32'h0,  1'b0,16'd0);
        add(1'b1,1'b0,1'b0,1'b0,32'h0,  1'b1, 3'd1,32'h1FC,1'b1,32'h1F8,1'b0,16'd0);
        add(1'b1,1'b0,1'b0,1'b0,32'h0,  1'b1, 3'd3,32'h1FC,1'b0,32'h1F8,1'b1,16'd1); // past end
        add(1'b1,1'b1,1'b0,1'b0,32'h0,  1'b1, 3'd3,32'h1FC,1'b0,32'h1F8,1'b1,16'd1);
        add(1'b0,1'b0,1'b0,1'b0,32'h0,  1'b0, 3'd0,32'h0,  1'b0,32'h0,  1'b0,16'd0);
        add(1'b1,1'b1,1'b0,1'b0,32'h0,  1'b0, 3'd1,32'h0,  1'b0,32'h0,  1'b0,16'd0);
        add(1'b1,1'b0,1'b0,1'b1,32'h200,1'b1, 3'd3,32'h0,  1'b0,32'h0,  1'b1,16'd0); // out of range

        @(negedge clk);
        foreach (vq[i]) begin
            rst_n = vq[i].rst_n; start = vq[i].start; halt_req = vq[i].halt;
            redirect_valid = vq[i].redir; redirect_pc = vq[i].rpc; out_ready = vq[i].ready;
            @(posedge clk);
            #1;
            chk("state",     i, 32'(state),       32'(vq[i].st));
            chk("pcaddress", i, pcaddress,        vq[i].pc);
            chk("out_valid", i, 32'(out_valid),   32'(vq[i].ov));
            chk("out_pc",    i, out_pc,           vq[i].opc);
            chk("fault",     i, 32'(fault),       32'(vq[i].flt));
            chk("count",     i, 32'(fetch_count), 32'(vq[i].cnt));
            if (vq[i].ov)         chk("out_instr", i, out_instr, mem[vq[i].opc[8:2]]);
            else if (!vq[i].rst_n) chk("out_instr_rst", i, out_instr, 32'h0);
        end

        rst_n = 1'b0; start = 1'b0; halt_req = 1'b0; redirect_valid = 1'b0; out_ready = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            if (c == 0) rst_n = 1'b0;
            else        rst_n = ($urandom_range(0, 39) != 0);
            start          = ($urandom_range(0, 3) == 0);
            halt_req       = ($urandom_range(0, 7) == 0);
            redirect_valid = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 7) == 0) redirect_pc = 32'($urandom_range(0, 1023));
            else                           redirect_pc = 32'(4 * $urandom_range(100, 127));
            out_ready      = ($urandom_range(0, 9) < 7);
            @(posedge clk);
            model_step();
            #1;
            chk("rnd_state", c, 32'(state),       32'(m_st));
            chk("rnd_pc",    c, pcaddress,        32'(m_pc));
            chk("rnd_valid", c, 32'(out_valid),   32'(m_ov));
            chk("rnd_fault", c, 32'(fault),       32'(m_flt));
            chk("rnd_count", c, 32'(fetch_count), 32'(m_cnt));
            if (m_ov) begin
                chk("rnd_out_pc",    c, out_pc,    32'(m_opc));
                chk("rnd_out_instr", c, out_instr, m_oins);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
